// File: rtl/down_count_pkg.sv
// Shared state encoding for the down-count sequencer and its helpers.
package down_count_pkg;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/down_count_sequencer_tick_prescaler.sv
// Mod-PRESCALE enable divider: pulses tick on the last enabled cycle of each period.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  // With PRESCALE=1, LAST is 0 and r_cnt never leaves 0, so tick follows en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/down_count_sequencer.sv
// Load/run/pause controller for a down-counter that pulses done at terminal count.
module down_count_sequencer
  import down_count_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_mode;
  logic             r_done;

  logic w_busy;
  logic w_accept;
  logic w_en;
  logic w_tick;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_accept = start_valid && (r_state == ST_IDLE) && !abort;
  // A PAUSED cycle with pause low already counts, so a pause of N cycles delays done by exactly N.
  assign w_en     = w_busy && !pause && !abort;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_accept || abort),
    .en   (w_en),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_RUN;
            r_count  <= load_val;
            r_reload <= load_val;
            r_mode   <= auto_reload;
          end
        end
        ST_RUN, ST_PAUSED: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else if (pause) begin
            r_state <= ST_PAUSED;
          end else begin
            r_state <= ST_RUN;
            if (w_tick) begin
              if (r_count != '0) begin
                r_count <= r_count - 1'b1;
              end else begin
                r_done <= 1'b1;
                if (r_mode) r_count <= r_reload;
                else        r_state <= ST_IDLE;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == ST_IDLE);
  assign busy        = w_busy;
  assign count       = r_count;
  assign done        = r_done;

endmodule

// File: tb/tb_down_count_sequencer.sv
// Directed bench: done pulses are checked against a queue of expected cycles; counts are checked inline.
module tb_down_count_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  int q1[$];
  int q4[$];

  // DUT with PRESCALE=1
  logic       sv1, rdy1, ar1, pa1, ab1, busy1, done1;
  logic [3:0] lv1, cnt1;
  // DUT with PRESCALE=4
  logic       sv4, rdy4, ar4, pa4, ab4, busy4, done4;
  logic [3:0] lv4, cnt4;

  down_count_sequencer #(.WIDTH(4), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(rdy1),
    .load_val(lv1), .auto_reload(ar1), .pause(pa1), .abort(ab1),
    .count(cnt1), .busy(busy1), .done(done1)
  );

  down_count_sequencer #(.WIDTH(4), .PRESCALE(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(rdy4),
    .load_val(lv4), .auto_reload(ar4), .pause(pa4), .abort(ab4),
    .count(cnt4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a start on u_p1; optionally push the done cycle for a one-shot run.
  task automatic start1(input logic [3:0] n, input logic ar, input int extra, input bit push);
    sv1 = 1'b1;
    lv1 = n;
    ar1 = ar;
    if (push) q1.push_back(cyc + 1 + (int'(n) + 1) + extra);
    step();
    sv1 = 1'b0;
    ar1 = 1'b0;
  endtask

  // Scoreboard monitors: every done pulse must match the next expected cycle.
  always @(posedge clk) begin
    #2;
    if (done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL p1_unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        chk("p1_done_cycle", cyc, q1.pop_front());
      end
    end
    if (done4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL p4_unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        chk("p4_done_cycle", cyc, q4.pop_front());
      end
    end
  end

  initial begin
    int a;
    logic [3:0] seq2 [9];
    logic [3:0] seq3 [9];
    seq2 = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
    seq3 = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    {sv1, ar1, pa1, ab1} = '0;
    {sv4, ar4, pa4, ab4} = '0;
    lv1 = '0;
    lv4 = '0;

    #3;
    chk("rst_count", cnt1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_ready", rdy1, 1);
    step();
    step();
    rst_n = 1'b1;

    // 1: one-shot load 3
    start1(4'd3, 1'b0, 0, 1'b1);
    chk("t1_count_e0", cnt1, 3);
    chk("t1_busy", busy1, 1);
    chk("t1_ready_busy", rdy1, 0);
    for (int unsigned k = 1; k <= 3; k++) begin
      step();
      chk("t1_count", cnt1, 3 - k);
    end
    step();
    chk("t1_done", done1, 1);
    chk("t1_count_end", cnt1, 0);
    chk("t1_idle_busy", busy1, 0);
    chk("t1_idle_ready", rdy1, 1);
    step();
    chk("t1_done_one_cycle", done1, 0);

    // 2 + 5: auto-reload load 2, ignored start while busy, abort on terminal tick
    start1(4'd2, 1'b1, 0, 1'b0);
    a = cyc;
    q1.push_back(a + 3);
    q1.push_back(a + 6);
    for (int unsigned k = 0; k < 9; k++) begin
      chk("t2_count", cnt1, seq2[k]);
      chk("t2_busy", busy1, 1);
      if (k == 4) begin
        sv1 = 1'b1;
        lv1 = 4'd7;
      end else begin
        sv1 = 1'b0;
      end
      if (k == 8) ab1 = 1'b1;
      if (k < 8) step();
    end
    step();
    ab1 = 1'b0;
    chk("t5_abort_done", done1, 0);
    chk("t5_abort_count", cnt1, 0);
    chk("t5_abort_busy", busy1, 0);
    chk("t5_abort_ready", rdy1, 1);
    step();

    // 3: PRESCALE=4, load 1 -> done 8 cycles after accept
    sv4 = 1'b1;
    lv4 = 4'd1;
    q4.push_back(cyc + 1 + 8);
    step();
    sv4 = 1'b0;
    for (int unsigned k = 0; k < 9; k++) begin
      chk("t3_count", cnt4, seq3[k]);
      if (k < 8) step();
    end
    chk("t3_busy_end", busy4, 0);
    chk("t3_ready_end", rdy4, 1);

    // 4: load 5 with a 5-cycle pause
    start1(4'd5, 1'b0, 5, 1'b1);
    chk("t4_count", cnt1, 5);
    step();
    chk("t4_count", cnt1, 4);
    step();
    chk("t4_count", cnt1, 3);
    pa1 = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      step();
      chk("t4_paused_count", cnt1, 3);
      chk("t4_paused_busy", busy1, 1);
    end
    pa1 = 1'b0;
    for (int unsigned k = 1; k <= 3; k++) begin
      step();
      chk("t4_resume_count", cnt1, 3 - k);
    end
    step();
    chk("t4_done", done1, 1);
    chk("t4_busy_end", busy1, 0);

    // 6: asynchronous reset mid-run
    start1(4'd9, 1'b0, 0, 1'b0);
    step();
    step();
    step();
    chk("t6_count_before", cnt1, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_count", cnt1, 0);
    chk("t6_async_busy", busy1, 0);
    chk("t6_async_done", done1, 0);
    chk("t6_async_ready", rdy1, 1);
    step();
    rst_n = 1'b1;
    start1(4'd0, 1'b0, 0, 1'b1);
    chk("t6_restart_busy", busy1, 1);
    chk("t6_restart_count", cnt1, 0);
    step();
    chk("t6_restart_done", done1, 1);
    chk("t6_restart_idle", busy1, 0);

    step();
    step();
    step();
    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
